// File: rtl/gmii_tx_sched.sv
// Chooses between the video and audio requesters for the GMII transmit engine.
// It issues the start handshake, enforces the inter-packet gap and runs the completion watchdog.
module gmii_tx_sched #(
   parameter logic [7:0]  VID_BURST    = 8'd4,
   parameter logic [15:0] AUD_MAX_WAIT = 16'd2000,
   parameter logic [7:0]  GAP_CYCLES   = 8'd12,
   parameter logic [15:0] TIMEOUT      = 16'd4000,
   parameter logic [3:0]  AUD_MAX_ADE  = 4'd8
) (
   input  logic        tx_clk,
   input  logic        sys_rst_n,
   input  logic        vid_rdy,
   input  logic        aud_rdy,
   input  logic [3:0]  aud_ade_num,
   output logic        tx_req,
   output logic        tx_type,
   output logic [3:0]  tx_ade_num,
   input  logic        tx_ack,
   input  logic        tx_done,
   output logic        busy,
   output logic        err_timeout,
   output logic [15:0] vid_pkt_cnt,
   output logic [15:0] aud_pkt_cnt
);

   // state | meaning
   // IDLE  | no packet in flight, arbitrate each cycle
   // REQ   | tx_req raised, waiting for engine tx_ack
   // XMIT  | engine sending, watchdog running until tx_done
   // GAP   | enforced idle time before the next arbitration
   typedef enum logic [1:0] {IDLE, REQ, XMIT, GAP} state_t;

   state_t      state_q, state_d;
   logic        tx_req_q, tx_req_d;
   logic        tx_type_q, tx_type_d;
   logic [3:0]  tx_ade_q, tx_ade_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [15:0] vid_cnt_q, vid_cnt_d;
   logic [15:0] aud_cnt_q, aud_cnt_d;
   logic [7:0]  vid_burst_q, vid_burst_d;
   logic [15:0] aud_wait_q, aud_wait_d;
   logic [15:0] wdog_q, wdog_d;
   logic [7:0]  gap_q, gap_d;

   logic        aud_pend, vid_pend, sel_aud, aud_granting, aud_served;
   logic [3:0]  ade_cap;
   logic [15:0] wdog_inc;

   always_comb begin
      state_d      = state_q;
      tx_req_d     = tx_req_q;
      tx_type_d    = tx_type_q;
      tx_ade_d     = tx_ade_q;
      err_d        = err_q;
      vid_cnt_d    = vid_cnt_q;
      aud_cnt_d    = aud_cnt_q;
      vid_burst_d  = vid_burst_q;
      aud_wait_d   = aud_wait_q;
      wdog_d       = wdog_q;
      gap_d        = gap_q;
      aud_granting = 1'b0;

      aud_pend = aud_rdy && (aud_ade_num != 4'd0);
      vid_pend = vid_rdy;
      sel_aud  = aud_pend && (!vid_pend || (aud_wait_q >= AUD_MAX_WAIT) ||
                              (vid_burst_q >= VID_BURST));
      ade_cap  = (aud_ade_num > AUD_MAX_ADE) ? AUD_MAX_ADE : aud_ade_num;
      wdog_inc = wdog_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (vid_pend || aud_pend) begin
               state_d   = REQ;
               tx_req_d  = 1'b1;
               tx_type_d = sel_aud;
               tx_ade_d  = sel_aud ? ade_cap : 4'd0;
            end
         end
         REQ: begin
            if (tx_ack) begin
               state_d  = XMIT;
               tx_req_d = 1'b0;
               wdog_d   = 16'd0;
               if (tx_type_q) begin
                  aud_cnt_d    = aud_cnt_q + 16'd1;
                  vid_burst_d  = 8'd0;
                  aud_granting = 1'b1;
               end else begin
                  vid_cnt_d = vid_cnt_q + 16'd1;
                  if (vid_burst_q != 8'hFF) vid_burst_d = vid_burst_q + 8'd1;
               end
            end
         end
         XMIT: begin
            wdog_d = wdog_inc;
            if (tx_done) begin
               state_d = GAP;
               gap_d   = GAP_CYCLES;
            end else if (wdog_inc == TIMEOUT) begin
               err_d   = 1'b1;
               state_d = GAP;
               gap_d   = GAP_CYCLES;
            end
         end
         GAP: begin
            // Leaving on the count of 1 makes the gap exactly GAP_CYCLES long.
            if (gap_q <= 8'd1) state_d = IDLE;
            else               gap_d   = gap_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase

      aud_served = (state_q == IDLE) ? sel_aud : tx_type_q;
      if (!aud_pend || aud_granting) aud_wait_d = 16'd0;
      else if (!aud_served && (aud_wait_q != 16'hFFFF)) aud_wait_d = aud_wait_q + 16'd1;

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge tx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         tx_req_q    <= 1'b0;
         tx_type_q   <= 1'b0;
         tx_ade_q    <= 4'd0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         vid_cnt_q   <= 16'd0;
         aud_cnt_q   <= 16'd0;
         vid_burst_q <= 8'd0;
         aud_wait_q  <= 16'd0;
         wdog_q      <= 16'd0;
         gap_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         tx_req_q    <= tx_req_d;
         tx_type_q   <= tx_type_d;
         tx_ade_q    <= tx_ade_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         vid_cnt_q   <= vid_cnt_d;
         aud_cnt_q   <= aud_cnt_d;
         vid_burst_q <= vid_burst_d;
         aud_wait_q  <= aud_wait_d;
         wdog_q      <= wdog_d;
         gap_q       <= gap_d;
      end
   end

   assign tx_req      = tx_req_q;
   assign tx_type     = tx_type_q;
   assign tx_ade_num  = tx_ade_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;
   assign vid_pkt_cnt = vid_cnt_q;
   assign aud_pkt_cnt = aud_cnt_q;

endmodule

// File: doc/gmii_tx_sched.md
Name: gmii_tx_sched

Overview:
- Arbitrates the single GMII transmit engine between two requesters: the video line FIFO and the audio/AUX FIFO.
- Decides which packet type is sent next and hands the engine a start command with the packet type and audio ADE count.
- Tracks packet completion and enforces an inter-packet gap and a completion watchdog.
- Sits in the tx_clk domain, between the FIFO status signals and the transmit engine's start/done handshake.

Parameters:
VID_BURST, 4, max consecutive video grants while audio is pending
AUD_MAX_WAIT, 16'd2000, tx_clk cycles audio may wait before it gets absolute priority
GAP_CYCLES, 8'd12, idle cycles enforced after each tx_done
TIMEOUT, 16'd4000, max cycles from tx_ack to tx_done before abort
AUD_MAX_ADE, 4'd8, cap on ADE blocks per audio packet

Ports:
tx_clk  in  1  transmit clock; the only clock
sys_rst_n  in  1  reset, asynchronous, active-low
vid_rdy  in  1  video FIFO holds a complete packet and send window is open
aud_rdy  in  1  audio FIFO not empty and ADE window valid
aud_ade_num  in  4  ADE blocks available for audio
tx_req  out  1  start request to transmit engine
tx_type  out  1  0 = video, 1 = audio; valid while tx_req
tx_ade_num  out  4  ADE count for audio packet; 0 for video
tx_ack  in  1  engine accepted request (left IDLE), 1-cycle pulse
tx_done  in  1  engine finished FCS, 1-cycle pulse
busy  out  1  high from grant until end of gap
err_timeout  out  1  sticky, set on watchdog expiry
vid_pkt_cnt  out  16  granted video packets, wraps
aud_pkt_cnt  out  16  granted audio packets, wraps

Behaviour:
- Reset, asynchronous and active-low: state = IDLE; all outputs 0; all counters 0.
- States: IDLE, REQ, XMIT, GAP.
- Audio is pending iff aud_rdy = 1 and aud_ade_num != 0. Video is pending iff vid_rdy = 1.
- IDLE, arbitration decision registered at the clock edge:
  - Both pending: select audio if aud_wait >= AUD_MAX_WAIT or vid_burst >= VID_BURST; otherwise select video.
  - Only one pending: select that one.
  - None pending: stay in IDLE.
  - On selection go to REQ with tx_req = 1.
  - tx_type and tx_ade_num are latched. tx_ade_num = min(aud_ade_num, AUD_MAX_ADE) for audio, 0 for video.
- REQ:
  - tx_req, tx_type and tx_ade_num are held stable until tx_ack.
  - On tx_ack: tx_req = 0 on the next cycle, state goes to XMIT, watchdog loads to 0.
  - Grant bookkeeping happens at tx_ack, not at request:
    - Video: vid_pkt_cnt +1; vid_burst +1, saturating.
    - Audio: aud_pkt_cnt +1; vid_burst = 0; aud_wait = 0.
  - Requester inputs are not re-sampled in REQ. A request is never withdrawn.
- XMIT:
  - Watchdog increments each cycle.
  - tx_done goes to GAP, with gap counter = GAP_CYCLES.
  - Watchdog == TIMEOUT sets err_timeout, then goes to GAP.
  - tx_done and timeout on the same cycle: tx_done wins and err_timeout is not set.
- GAP: counter decrements; at 0 go to IDLE. With GAP_CYCLES = 0, return to IDLE the next cycle.
- busy = 1 in REQ, XMIT and GAP; 0 in IDLE.
- aud_wait (16-bit, saturating at 16'hFFFF):
  - Increments every cycle audio is pending and the current/next grant is not audio, including while video is in XMIT/GAP.
  - Cleared when audio is not pending.
- tx_ack outside REQ and tx_done outside XMIT are ignored.
- err_timeout is cleared only by reset.
- Counter widths: vid_burst 8-bit saturating; packet counters wrap FFFF -> 0000.

Test Plan:
- Reset and idle: assert sys_rst_n = 0 mid-XMIT. Outputs go to 0 immediately, without waiting for a clock. Release with no requests: tx_req stays 0, busy = 0.
- Video only: hold vid_rdy = 1; ack 2 cycles after each req; done 100 cycles after ack.
  - tx_type = 0 and tx_ade_num = 0 on every grant.
  - Next tx_req rises 12 + 1 cycles after tx_done.
  - vid_pkt_cnt = 5 after 5 packets.
- Burst limit: vid_rdy = 1 continuously; audio pending with aud_ade_num = 3.
  - Grant sequence is V,V,V,V,A,V,V,V,V,A.
  - Audio grants carry tx_ade_num = 3.
- Starvation: VID_BURST = 255, AUD_MAX_WAIT = 300, video packets 200 cycles long, audio raised during the first video XMIT.
  - Audio is granted at the first IDLE after aud_wait reaches 300.
  - aud_wait is 0 after that ack.
- ADE cap and zero: aud_ade_num = 12 gives tx_ade_num = 8. aud_ade_num = 0 with aud_rdy = 1 gives no grant.
- Watchdog:
  - Withhold tx_done after ack: err_timeout = 1 exactly TIMEOUT cycles after the ack, then GAP, then IDLE. It stays 1 afterwards.
  - Repeat with tx_done on the expiry cycle: err_timeout stays 0.
